// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
// ----------------------------------------------------------------------------
// Iterative HI/LO unit for a MIPS-style pipeline. Executes MULT, MULTU, DIV
// and DIVU with a radix-2 datapath, one step per clock, and handles MTHI/MTLO
// as single-edge register writes.
//
// Operation timeline for a multiply or divide:
//   accept edge (IDLE -> RUN), 32 RUN edges (one step each, RUN -> FIX on the
//   last), FIX edge (sign-correct, write HI/LO, FIX -> IDLE).
//   Busy is therefore high for 33 cycles, and the new HI/LO appear in the
//   cycle where Busy drops. Division by zero skips RUN entirely.
//
// Ports:
//   clock          system clock, rising-edge active
//   reset          synchronous active-high reset
//   EX_Op          3-bit HI/LO opcode in EX (0 none, 1 MULT, 2 MULTU, 3 DIV,
//                  4 DIVU, 5 MTHI, 6 MTLO, 7 reserved/none)
//   EX_Valid       EX instruction is live
//   EX_Rs_Data     Rs operand (multiplicand / dividend / MTHI-MTLO source)
//   EX_Rt_Data     Rt operand (multiplier / divisor)
//   ID_Reads_HiLo  MFHI/MFLO sitting in ID
//   HI, LO         architectural HI/LO registers
//   Busy           unit is mid-operation (state != IDLE)
//   EX_Stall_Req   hold EX: a HI/LO op is waiting while the unit is busy
//   ID_Stall_Req   hold ID: an MFHI/MFLO is waiting while the unit is busy
// ============================================================================
module muldiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  EX_Op,
    input  logic        EX_Valid,
    input  logic [31:0] EX_Rs_Data,
    input  logic [31:0] EX_Rt_Data,
    input  logic        ID_Reads_HiLo,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        EX_Stall_Req,
    output logic        ID_Stall_Req
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  count;

    // acc is shared by both algorithms.
    //   multiply: acc[63:32] partial product, acc[31:0] multiplier being
    //             shifted out as product bits shift in
    //   divide:   acc[63:32] partial remainder, acc[31:0] dividend being
    //             shifted out as quotient bits shift in
    logic [63:0] acc;
    logic [31:0] op_a;          // |multiplicand| or |divisor|
    logic        is_div;
    logic        neg_main;      // negate product / quotient in FIX
    logic        neg_rem;       // negate remainder in FIX
    logic        div_zero;

    // Opcode decode
    logic        op_is_mult;
    logic        op_is_div;
    logic        op_is_signed;
    logic        op_is_live;
    logic        accept_arith;
    logic        accept_div_zero;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;

    // Step datapaths
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shifted;
    logic [32:0] div_diff;
    logic [63:0] div_next;

    // FIX-stage results
    logic [63:0] prod_fixed;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;

    // ------------------------------------------------------------------------
    // Opcode decode and operand magnitude extraction. Signed ops work on
    // absolute values; 0x80000000 maps to itself, which is the correct
    // unsigned magnitude.
    // ------------------------------------------------------------------------
    always_comb begin
        op_is_mult      = EX_Valid && ((EX_Op == OP_MULT) || (EX_Op == OP_MULTU));
        op_is_div       = EX_Valid && ((EX_Op == OP_DIV)  || (EX_Op == OP_DIVU));
        op_is_signed    = (EX_Op == OP_MULT) || (EX_Op == OP_DIV);
        op_is_live      = EX_Valid && (EX_Op != 3'd0) && (EX_Op != 3'd7);
        accept_arith    = (state == IDLE) && (op_is_mult || op_is_div);
        accept_div_zero = op_is_div && (EX_Rt_Data == 32'd0);
        rs_abs = (op_is_signed && EX_Rs_Data[31]) ? (~EX_Rs_Data + 32'd1) : EX_Rs_Data;
        rt_abs = (op_is_signed && EX_Rt_Data[31]) ? (~EX_Rt_Data + 32'd1) : EX_Rt_Data;
    end

    // ------------------------------------------------------------------------
    // One radix-2 step of each algorithm.
    // Multiply: conditionally add the multiplicand into the upper half, then
    // shift the whole 65-bit result right by one.
    // Restoring divide: shift the next dividend bit into the remainder, try
    // subtracting the divisor, keep the difference only if it did not borrow.
    // ------------------------------------------------------------------------
    always_comb begin
        mul_sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, op_a} : 33'd0);
        mul_next    = {mul_sum, acc[31:1]};
        div_shifted = {acc[63:32], acc[31]};
        div_diff    = div_shifted - {1'b0, op_a};
        if (div_diff[32]) begin
            div_next = {div_shifted[31:0], acc[30:0], 1'b0};
        end else begin
            div_next = {div_diff[31:0], acc[30:0], 1'b1};
        end
    end

    // ------------------------------------------------------------------------
    // Sign correction applied in FIX.
    // ------------------------------------------------------------------------
    always_comb begin
        prod_fixed = neg_main ? (~acc + 64'd1) : acc;
        quo_fixed  = neg_main ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fixed  = neg_rem  ? (~acc[63:32] + 32'd1) : acc[63:32];
    end

    // ------------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and status outputs. Stall requests are only ever raised
    // while busy, so an idle unit never holds the pipeline.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        Busy         = (state != IDLE);
        EX_Stall_Req = 1'b0;
        ID_Stall_Req = 1'b0;

        if (Busy) begin
            EX_Stall_Req = op_is_live;
            ID_Stall_Req = ID_Reads_HiLo;
        end

        case (state)
            IDLE: begin
                if (accept_arith) begin
                    state_next = accept_div_zero ? FIX : RUN;
                end
            end
            RUN: begin
                if (count == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and HI/LO. HI/LO change only on MTHI/MTLO in IDLE or in FIX;
    // a reset mid-operation discards the partial result.
    // For a zero divisor the raw dividend is parked in acc[31:0] so FIX can
    // return it unmodified in HI.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= 5'd0;
            acc      <= 64'd0;
            op_a     <= 32'd0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (EX_Valid && (EX_Op == OP_MTHI)) begin
                        HI <= EX_Rs_Data;
                    end
                    if (EX_Valid && (EX_Op == OP_MTLO)) begin
                        LO <= EX_Rs_Data;
                    end
                    if (accept_arith) begin
                        count    <= 5'd0;
                        op_a     <= rt_abs;
                        acc      <= {32'd0, accept_div_zero ? EX_Rs_Data : rs_abs};
                        is_div   <= op_is_div;
                        neg_main <= op_is_signed && (EX_Rs_Data[31] ^ EX_Rt_Data[31]);
                        neg_rem  <= op_is_signed && EX_Rs_Data[31];
                        div_zero <= accept_div_zero;
                    end
                end
                RUN: begin
                    count <= count + 5'd1;
                    acc   <= is_div ? div_next : mul_next;
                end
                FIX: begin
                    if (div_zero) begin
                        LO <= 32'hFFFF_FFFF;
                        HI <= acc[31:0];
                    end else if (is_div) begin
                        LO <= quo_fixed;
                        HI <= rem_fixed;
                    end else begin
                        LO <= prod_fixed[31:0];
                        HI <= prod_fixed[63:32];
                    end
                end
                default: begin
                    count <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL provide port: reset  input  1  synchronous, active-high reset, sampled on rising clock edge.
REQ-003 SHALL provide port: EX_Op  input  3  EX-stage HI/LO opcode: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
REQ-004 SHALL provide port: EX_Valid  input  1  EX instruction is live (not bubble, not flushed).
REQ-005 SHALL provide port: EX_Rs_Data  input  32  forwarded Rs operand (multiplicand / dividend / MTHI-MTLO source).
REQ-006 SHALL provide port: EX_Rt_Data  input  32  forwarded Rt operand (multiplier / divisor).
REQ-007 SHALL provide port: ID_Reads_HiLo  input  1  MFHI/MFLO is in ID.
REQ-008 SHALL provide port: HI  output  32  architectural HI register.
REQ-009 SHALL provide port: LO  output  32  architectural LO register.
REQ-010 SHALL provide port: Busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL provide port: EX_Stall_Req  output  1  Busy & EX_Valid & EX_Op in 001..110; ORed into EX_Stall by stall logic.
REQ-012 SHALL provide port: ID_Stall_Req  output  1  Busy & ID_Reads_HiLo; ORed into ID_Stall.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX; Busy = (state != IDLE), combinational from state.
REQ-014 SHALL accept an operation only in IDLE with EX_Valid=1; in any other state EX_Op is ignored (held by EX_Stall_Req).
REQ-015 SHALL, for MTHI/MTLO accepted in IDLE, load HI/LO from EX_Rs_Data on that edge and remain IDLE (zero-cycle busy).
REQ-016 SHALL, for MULT/MULTU/DIV/DIVU accepted in IDLE, latch operands, clear 5-bit count, enter RUN.
REQ-017 SHALL, for signed ops, latch absolute values plus result-sign flags (product/quotient sign = Rs[31]^Rt[31]; remainder sign = Rs[31]).
REQ-018 SHALL in RUN perform one radix-2 step per cycle: multiply = shift-add into 64-bit accumulator; divide = restoring shift-subtract producing 1 quotient bit.
REQ-019 SHALL leave RUN for FIX after exactly 32 RUN cycles (count 31 -> wrap).
REQ-020 SHALL in FIX apply sign correction, write HI/LO (mult: HI=product[63:32], LO=product[31:0]; div: LO=quotient, HI=remainder), return to IDLE.
REQ-021 SHALL therefore hold Busy high for exactly 33 cycles after accepting a mult/div; new HI/LO visible in the cycle Busy falls.
REQ-022 SHALL, on DIV/DIVU with EX_Rt_Data=0, skip RUN, go directly to FIX, write LO=32'hFFFFFFFF, HI=EX_Rs_Data (Busy 1 cycle).
REQ-023 SHALL produce for DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
REQ-024 SHALL keep HI/LO unchanged during RUN; only FIX or MTHI/MTLO modify them.
REQ-025 SHALL NOT raise EX_Stall_Req or ID_Stall_Req while IDLE, irrespective of inputs.
REQ-026 SHALL ignore EX_Valid=0 and opcode 000/111 in every state.

Reset
REQ-027 SHALL on reset=1 force state=IDLE, count=0, HI=0, LO=0, Busy=0, EX_Stall_Req=0, ID_Stall_Req=0, including mid-RUN/FIX (operation aborted, no HI/LO write).
REQ-028 SHALL give reset priority over any operation accept on the same edge.

Verification
REQ-029 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 Busy cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 SHALL cover: MULT 0xFFFFFFFE (-2) x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 SHALL cover: DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 100/7 -> LO=14, HI=2.
REQ-032 SHALL cover: DIVU 5/0 -> Busy exactly 1 cycle, LO=0xFFFFFFFF, HI=5.
REQ-033 SHALL cover: MFHI in ID and MTLO in EX during RUN -> ID_Stall_Req=1, EX_Stall_Req=1 each Busy cycle; MTLO takes effect on first IDLE edge.
REQ-034 SHALL cover: reset asserted at RUN count 10 -> next cycle Busy=0, HI=LO=0; subsequent MULTU 3x4 -> LO=12, HI=0.
